pool2_ctrl: RTL and testbench
=============================

POOL2_CTRL -- requirements
Module: pool2_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 10: input feature-map width and height (f4 map is IN_W x IN_W).
REQ-002 SHALL have parameter RA_W, default 7: f4 read-address width.
REQ-003 SHALL have parameter WA_W, default 5: f5 write-address width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port pool2_start, input, 1: one-cycle request to pool all 16 maps.
REQ-007 SHALL have port pool2_busy, output, 1: high from the cycle after an accepted start until the pool2_done cycle, inclusive.
REQ-008 SHALL have port pool2_done, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port f4_ren, output, 1: read enable shared by the 16 f4 RAMs.
REQ-010 SHALL have port f4_raddr, output, RA_W: read address shared by the 16 f4 RAMs.
REQ-011 SHALL have port pool2_clr, output, 1: window-restart strobe to the 16 pool units.
REQ-012 SHALL have port f5_wen, output, 1: write enable shared by the 16 f5 RAMs.
REQ-013 SHALL have port f5_waddr, output, WA_W: write address shared by the 16 f5 RAMs.

Function
REQ-014 SHALL use OUT_W = IN_W/2; each output (r,c), with r,c in 0..OUT_W-1, pools one 2x2 window.
REQ-015 SHALL, per window, issue exactly 4 reads on consecutive cycles, phases k=0..3, at addresses 2r*IN_W+2c, +1, +IN_W, +IN_W+1, with f4_ren=1 each cycle.
REQ-016 SHALL scan windows in raster order (c fastest), back-to-back with no idle cycles; total 4*OUT_W*OUT_W read cycles (100 at default).
REQ-017 SHALL treat f4 RAM read latency as 1 cycle: data for the read issued in cycle t is valid on f4_*_rdata in cycle t+1.
REQ-018 SHALL assert pool2_clr in the cycle where phase-0 data is valid (issue cycle +1), and only then; the pool unit loads d_in when clr=1, else keeps max(acc,d_in).
REQ-019 SHALL assert f5_wen, with f5_waddr = r*OUT_W+c, exactly 5 cycles after that window's phase-0 issue cycle, when the pool unit output holds the 4-element max.
REQ-020 SHALL allow f5_wen of window n and pool2_clr of window n+1 in the same cycle.
REQ-021 SHALL implement states IDLE -> RUN (issuing reads) -> FLUSH (2 cycles, no reads, draining clr/wen pipeline) -> DONE (1 cycle, pool2_done=1) -> IDLE.
REQ-022 SHALL accept pool2_start only in IDLE; start in any other state SHALL be ignored.
REQ-023 SHALL, with phase-0 issue of window 0 in cycle 0, produce the last f5_wen in cycle 4*OUT_W*OUT_W+1 and pool2_done in the next cycle.
REQ-024 SHALL drive f4_raddr=0 and f5_waddr=0 whenever the corresponding enable is low.
REQ-025 SHALL begin the first read in the cycle after start is sampled.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, enter IDLE and clear counters and pipeline registers; all outputs 0 the following cycle.
REQ-027 SHALL abort any in-progress run on reset without asserting f5_wen or pool2_done; a new start is accepted after reset.

Structure
REQ-028 SHALL take IN_W, OUT_W, RA_W and WA_W defaults from the shared LeNet constants package used by the other pool and conv controllers.
REQ-029 SHALL place window/phase counting and address arithmetic in one sub-module, pool2_addr_gen; pool2_ctrl holds the FSM and the clr/wen delay pipeline.

Verification
REQ-030 SHALL cover start pulse from reset: reads in cycles 1..100, f4_raddr cycles 1..4 = 0,1,10,11; cycles 5..8 = 2,3,12,13; f5_wen cycles 6..102 every 4, waddr 0..24; pool2_done at cycle 103.
REQ-031 SHALL cover end-to-end with RAM and pool-unit models: f4 loaded with addr value, expected f5[i] = 2r*10+2c+11.
REQ-032 SHALL cover window (4,4): reads 88,89,98,99; f5_wen with waddr 24.
REQ-033 SHALL cover start re-pulsed at cycle 50 and at done cycle: ignored, sequence unchanged.
REQ-034 SHALL cover rst_n low at cycle 40 for 1 cycle: outputs 0 next cycle, no done; a restart gives the full 25 writes.
REQ-035 SHALL cover clr/wen overlap: verify the pool unit writes the correct max when clr and wen share a cycle, using descending input values.

Source files
------------

// File: rtl/pool2_ctrl_pkg.sv
// Shared LeNet dimension constants and the pool2 controller state encoding.
package pool2_ctrl_pkg;

    localparam int LENET_F4_W     = 10;
    localparam int LENET_F4_OUT_W = LENET_F4_W / 2;
    localparam int LENET_F4_RA_W  = 7;
    localparam int LENET_F5_WA_W  = 5;

    // Phase-0 issue to f5 write: 1 cycle RAM latency + 4 accumulate edges.
    localparam int POOL2_WEN_LAT  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pool2_state_e;

endpackage

// File: rtl/pool2_addr_gen.sv
// Window/phase counters and f4 read-address arithmetic for 2x2 pooling.
module pool2_addr_gen
    import pool2_ctrl_pkg::*;
#(
    parameter int IN_W = LENET_F4_W,
    parameter int RA_W = LENET_F4_RA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            adv_i,
    output logic [RA_W-1:0] addr_o,
    output logic            phase0_o,
    output logic            last_o
);

    localparam int OUT_W = IN_W / 2;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CW-1:0] CMAX = CW'(OUT_W - 1);

    logic [1:0]      ph_q, ph_d;
    logic [CW-1:0]   c_q, c_d, r_q, r_d;
    logic [RA_W-1:0] base_q, base_d;
    logic [RA_W-1:0] offs;

    // base_q tracks 2r*IN_W+2c so no multiplier is needed.
    always_comb begin
        ph_d   = ph_q;
        c_d    = c_q;
        r_d    = r_q;
        base_d = base_q;
        if (clr_i) begin
            ph_d   = '0;
            c_d    = '0;
            r_d    = '0;
            base_d = '0;
        end else if (adv_i) begin
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd3) begin
                if (c_q == CMAX) begin
                    c_d = '0;
                    if (r_q == CMAX) begin
                        r_d    = '0;
                        base_d = '0;
                    end else begin
                        r_d    = r_q + 1'b1;
                        base_d = base_q + RA_W'(IN_W + 2);
                    end
                end else begin
                    c_d    = c_q + 1'b1;
                    base_d = base_q + RA_W'(2);
                end
            end
        end
    end

    always_comb begin
        case (ph_q)
            2'd0:    offs = '0;
            2'd1:    offs = RA_W'(1);
            2'd2:    offs = RA_W'(IN_W);
            default: offs = RA_W'(IN_W + 1);
        endcase
    end

    assign addr_o   = base_q + offs;
    assign phase0_o = (ph_q == 2'd0);
    assign last_o   = (ph_q == 2'd3) && (c_q == CMAX) && (r_q == CMAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_q   <= '0;
            c_q    <= '0;
            r_q    <= '0;
            base_q <= '0;
        end else begin
            ph_q   <= ph_d;
            c_q    <= c_d;
            r_q    <= r_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/pool2_ctrl.sv
// Pool2 sequencer: FSM plus the clr/wen delay pipeline aligned to the f4 read stream.
module pool2_ctrl
    import pool2_ctrl_pkg::*;
#(
    parameter int IN_W = LENET_F4_W,
    parameter int RA_W = LENET_F4_RA_W,
    parameter int WA_W = LENET_F5_WA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pool2_start,
    output logic            pool2_busy,
    output logic            pool2_done,
    output logic            f4_ren,
    output logic [RA_W-1:0] f4_raddr,
    output logic            pool2_clr,
    output logic            f5_wen,
    output logic [WA_W-1:0] f5_waddr
);

    pool2_state_e state_q, state_d;
    logic         flush_q, flush_d;
    logic [POOL2_WEN_LAT:1] vld_pipe_q, vld_pipe_d;
    logic [WA_W-1:0] wcnt_q, wcnt_d;

    logic            ag_clr, ag_adv, ag_phase0, ag_last;
    logic [RA_W-1:0] ag_addr;

    pool2_addr_gen #(
        .IN_W (IN_W),
        .RA_W (RA_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (ag_clr),
        .adv_i    (ag_adv),
        .addr_o   (ag_addr),
        .phase0_o (ag_phase0),
        .last_o   (ag_last)
    );

    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        ag_clr  = 1'b0;
        ag_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pool2_start) begin
                    state_d = ST_RUN;
                    ag_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                ag_adv = 1'b1;
                if (ag_last) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_d = ~flush_q;
                if (flush_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit k is set k cycles after a phase-0 read: bit 1 = clr, top bit = wen.
    assign vld_pipe_d = {vld_pipe_q[POOL2_WEN_LAT-1:1], (state_q == ST_RUN) && ag_phase0};

    always_comb begin
        wcnt_d = wcnt_q;
        if (ag_clr)      wcnt_d = '0;
        else if (f5_wen) wcnt_d = wcnt_q + 1'b1;
    end

    assign f4_ren     = (state_q == ST_RUN);
    assign f4_raddr   = f4_ren ? ag_addr : '0;
    assign pool2_clr  = vld_pipe_q[1];
    assign f5_wen     = vld_pipe_q[POOL2_WEN_LAT];
    assign f5_waddr   = f5_wen ? wcnt_q : '0;
    assign pool2_busy = (state_q != ST_IDLE);
    assign pool2_done = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            flush_q    <= 1'b0;
            vld_pipe_q <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            vld_pipe_q <= vld_pipe_d;
            wcnt_q     <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_pool2_ctrl.sv
// Directed bench for pool2_ctrl with f4 RAM, pool-unit and f5 RAM models.
module tb_pool2_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pool2_start;
    logic       pool2_busy, pool2_done;
    logic       f4_ren, pool2_clr, f5_wen;
    logic [6:0] f4_raddr;
    logic [4:0] f5_waddr;

    int n_cmp = 0;
    int n_bad = 0;

    logic       mem_desc;
    logic       f5_clr;
    logic [7:0] rdata, acc;
    int         f5 [0:31];
    int         wr_cnt;
    int         rec_raddr [0:127];

    always #5 clk = ~clk;

    pool2_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pool2_start (pool2_start),
        .pool2_busy  (pool2_busy),
        .pool2_done  (pool2_done),
        .f4_ren      (f4_ren),
        .f4_raddr    (f4_raddr),
        .pool2_clr   (pool2_clr),
        .f5_wen      (f5_wen),
        .f5_waddr    (f5_waddr)
    );

    // f4 holds addr (or 255-addr); pool unit and f5 RAM as described by the block interface.
    always @(posedge clk) begin
        if (f4_ren) rdata <= mem_desc ? 8'(255 - int'(f4_raddr)) : 8'(f4_raddr);
        if (pool2_clr) acc <= rdata;
        else if (rdata > acc) acc <= rdata;
        if (f5_clr) begin
            wr_cnt <= 0;
            for (int i = 0; i < 32; i++) f5[i] <= -1;
        end else if (f5_wen) begin
            f5[f5_waddr] <= int'(acc);
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain run, 1: start re-pulsed at 50 and 103, 2: reset during cycle 40.
    task automatic run_seq(input int mode);
        int tbl [0:7];
        int t44 [0:3];
        tbl = '{0, 1, 10, 11, 2, 3, 12, 13};
        t44 = '{88, 89, 98, 99};
        f5_clr = 1'b1;
        step();
        f5_clr = 1'b0;
        pool2_start = 1'b1;
        step();
        for (int k = 1; k <= 115; k++) begin
            bit ab, e_ren, e_clr, e_wen;
            int idx, w, ph, e_addr;
            pool2_start = (mode == 1) && (k == 50 || k == 103);
            rst_n = !((mode == 2) && (k == 40));
            ab     = (mode == 2) && (k > 40);
            e_ren  = !ab && k >= 1 && k <= 100;
            idx    = k - 1;
            w      = idx / 4;
            ph     = idx % 4;
            e_addr = 0;
            if (e_ren)
                e_addr = 20 * (w / 5) + 2 * (w % 5) + (ph == 1 ? 1 : ph == 2 ? 10 : ph == 3 ? 11 : 0);
            e_clr = !ab && k >= 2 && k <= 98 && ((k - 2) % 4 == 0);
            e_wen = !ab && k >= 6 && k <= 102 && ((k - 6) % 4 == 0);
            rec_raddr[k] = int'(f4_raddr);
            check($sformatf("ren@%0d", k),   int'(f4_ren), int'(e_ren));
            check($sformatf("raddr@%0d", k), int'(f4_raddr), e_addr);
            check($sformatf("clr@%0d", k),   int'(pool2_clr), int'(e_clr));
            check($sformatf("wen@%0d", k),   int'(f5_wen), int'(e_wen));
            check($sformatf("waddr@%0d", k), int'(f5_waddr), e_wen ? (k - 6) / 4 : 0);
            check($sformatf("done@%0d", k),  int'(pool2_done), int'(!ab && k == 103));
            check($sformatf("busy@%0d", k),  int'(pool2_busy), int'(!ab && k >= 1 && k <= 103));
            if (k == 102 && !ab) check("waddr_win44", int'(f5_waddr), 24);
            step();
        end
        rst_n = 1'b1;
        pool2_start = 1'b0;
        if (mode != 2) begin
            for (int i = 0; i < 8; i++) check($sformatf("tbl_raddr@%0d", i + 1), rec_raddr[i + 1], tbl[i]);
            for (int i = 0; i < 4; i++) check($sformatf("win44_raddr@%0d", i + 97), rec_raddr[i + 97], t44[i]);
            check("wr_cnt", wr_cnt, 25);
        end else begin
            check("wr_cnt_abort", wr_cnt, 9);
        end
    endtask

    task automatic check_f5(input bit desc);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                check($sformatf("f5[%0d]", r * 5 + c), f5[r * 5 + c],
                      desc ? 255 - (20 * r + 2 * c) : 20 * r + 2 * c + 11);
    endtask

    initial begin
        rst_n       = 1'b0;
        pool2_start = 1'b0;
        f5_clr      = 1'b0;
        mem_desc    = 1'b0;
        step();
        step();
        check("rst_busy",  int'(pool2_busy), 0);
        check("rst_done",  int'(pool2_done), 0);
        check("rst_ren",   int'(f4_ren), 0);
        check("rst_raddr", int'(f4_raddr), 0);
        check("rst_clr",   int'(pool2_clr), 0);
        check("rst_wen",   int'(f5_wen), 0);
        check("rst_waddr", int'(f5_waddr), 0);
        rst_n = 1'b1;
        step();

        run_seq(0);
        check_f5(1'b0);
        run_seq(1);
        check_f5(1'b0);
        run_seq(2);
        run_seq(0);
        check_f5(1'b0);
        mem_desc = 1'b1;
        run_seq(0);
        check_f5(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
